graph_mem_arbiter: RTL and testbench

Round-robin arbiter that shares graph_memory among NUM_PROCS processing elements.
- Every cycle it grants up to one idx (row-pointer) read and up to two data reads, one on each of port A and port B.
- It tags each issued read with the requester id and routes the returned word back to that requester after the fixed BRAM latency.
- Sits between the PE array and graph_memory; it is the only driver of graph_memory's address/valid inputs.

---
 rtl/graph_mem_arbiter_if.sv | 34 +++
 rtl/graph_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_graph_mem_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/graph_mem_arbiter_if.sv
// PE-array request/response bundle plus the graph_memory address/data side.
interface graph_mem_arbiter_if #(
  parameter int NUM_PROCS = 4,
  parameter int PROC_BITS = 2
);
  logic [NUM_PROCS-1:0]         req_valid_in;
  logic [NUM_PROCS-1:0]         req_kind_in;
  logic [NUM_PROCS-1:0][31:0]   req_addr_in;
  logic [NUM_PROCS-1:0]         req_ready_out;
  logic [31+PROC_BITS:0]        idx_addr_out;
  logic                         idx_valid_out;
  logic [31+PROC_BITS:0]        data_addra_out;
  logic                         data_validina_out;
  logic [31+PROC_BITS:0]        data_addrb_out;
  logic                         data_validinb_out;
  logic [31:0]                  rowidx_in;
  logic [31:0]                  data_a_in;
  logic [31:0]                  data_b_in;
  logic [NUM_PROCS-1:0]         resp_valid_out;
  logic [NUM_PROCS-1:0][31:0]   resp_data_out;
  logic [PROC_BITS+2:0]         inflight_out;

  modport slave (
    input  req_valid_in, req_kind_in, req_addr_in, rowidx_in, data_a_in, data_b_in,
    output req_ready_out, idx_addr_out, idx_valid_out, data_addra_out, data_validina_out,
           data_addrb_out, data_validinb_out, resp_valid_out, resp_data_out, inflight_out
  );

  modport master (
    output req_valid_in, req_kind_in, req_addr_in, rowidx_in, data_a_in, data_b_in,
    input  req_ready_out, idx_addr_out, idx_valid_out, data_addra_out, data_validina_out,
           data_addrb_out, data_validinb_out, resp_valid_out, resp_data_out, inflight_out
  );
endinterface

// File: rtl/graph_mem_arbiter.sv
// Round-robin arbiter sharing graph_memory (one idx port, two data ports) among NUM_PROCS PEs,
// tagging each read with its requester id and routing the word back after READ_LATENCY.
module graph_mem_arbiter #(
  parameter int NUM_PROCS    = 4,
  parameter int PROC_BITS    = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic               clk_in,
  input  logic               rst_in,
  graph_mem_arbiter_if.slave bus
);
  localparam int AW = 32 + PROC_BITS;
  localparam int CW = PROC_BITS + 3;

  typedef logic [PROC_BITS-1:0] id_t;
  typedef struct packed {
    logic vld;
    id_t  id;
  } tag_t;

  id_t                     idx_ptr_q, data_ptr_q;
  id_t                     idx_id, a_id, b_id, scan_j;
  logic                    idx_gnt, a_gnt, b_gnt;
  logic                    idx_valid_q, a_valid_q, b_valid_q;
  logic [AW-1:0]           idx_addr_q, a_addr_q, b_addr_q;
  tag_t [READ_LATENCY-1:0] idx_tag_q, a_tag_q, b_tag_q;
  tag_t                    idx_out, a_out, b_out;
  logic [CW-1:0]           inflight_q, inflight_d;

  function automatic id_t wrap_inc(input id_t id);
    return (int'(id) == NUM_PROCS - 1) ? '0 : id + 1'b1;
  endfunction

  // Idx and data scans run independently; a PE can only hit one of them since kind picks the target.
  always_comb begin
    scan_j            = '0;
    idx_gnt           = 1'b0;
    idx_id            = '0;
    a_gnt             = 1'b0;
    a_id              = '0;
    b_gnt             = 1'b0;
    b_id              = '0;
    bus.req_ready_out = '0;
    if (!rst_in) begin
      for (int k = 0; k < NUM_PROCS; k++) begin
        scan_j = id_t'((int'(idx_ptr_q) + k) % NUM_PROCS);
        if (!idx_gnt && bus.req_valid_in[scan_j] && !bus.req_kind_in[scan_j]) begin
          idx_gnt = 1'b1;
          idx_id  = scan_j;
        end
        scan_j = id_t'((int'(data_ptr_q) + k) % NUM_PROCS);
        if (bus.req_valid_in[scan_j] && bus.req_kind_in[scan_j]) begin
          if (!a_gnt) begin
            a_gnt = 1'b1;
            a_id  = scan_j;
          end else if (!b_gnt) begin
            b_gnt = 1'b1;
            b_id  = scan_j;
          end
        end
      end
      if (idx_gnt) bus.req_ready_out[idx_id] = 1'b1;
      if (a_gnt)   bus.req_ready_out[a_id]   = 1'b1;
      if (b_gnt)   bus.req_ready_out[b_id]   = 1'b1;
    end
  end

  assign idx_out = idx_tag_q[READ_LATENCY-1];
  assign a_out   = a_tag_q[READ_LATENCY-1];
  assign b_out   = b_tag_q[READ_LATENCY-1];

  assign inflight_d = inflight_q + CW'(idx_gnt) + CW'(a_gnt) + CW'(b_gnt)
                    - CW'(idx_out.vld) - CW'(a_out.vld) - CW'(b_out.vld);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      idx_ptr_q   <= '0;
      data_ptr_q  <= '0;
      idx_valid_q <= 1'b0;
      a_valid_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      idx_addr_q  <= '0;
      a_addr_q    <= '0;
      b_addr_q    <= '0;
      idx_tag_q   <= '0;
      a_tag_q     <= '0;
      b_tag_q     <= '0;
      inflight_q  <= '0;
    end else begin
      idx_valid_q <= idx_gnt;
      a_valid_q   <= a_gnt;
      b_valid_q   <= b_gnt;
      if (idx_gnt) begin
        idx_addr_q <= {idx_id, bus.req_addr_in[idx_id]};
        idx_ptr_q  <= wrap_inc(idx_id);
      end
      if (a_gnt) a_addr_q <= {a_id, bus.req_addr_in[a_id]};
      if (b_gnt) b_addr_q <= {b_id, bus.req_addr_in[b_id]};
      if (b_gnt)      data_ptr_q <= wrap_inc(b_id);
      else if (a_gnt) data_ptr_q <= wrap_inc(a_id);
      // Tags enter alongside the memory valid so they leave exactly when the word does.
      idx_tag_q[0] <= {idx_valid_q, idx_addr_q[32 +: PROC_BITS]};
      a_tag_q[0]   <= {a_valid_q, a_addr_q[32 +: PROC_BITS]};
      b_tag_q[0]   <= {b_valid_q, b_addr_q[32 +: PROC_BITS]};
      for (int s = 1; s < READ_LATENCY; s++) begin
        idx_tag_q[s] <= idx_tag_q[s-1];
        a_tag_q[s]   <= a_tag_q[s-1];
        b_tag_q[s]   <= b_tag_q[s-1];
      end
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    bus.resp_valid_out = '0;
    bus.resp_data_out  = '0;
    if (!rst_in) begin
      if (idx_out.vld) begin
        bus.resp_valid_out[idx_out.id] = 1'b1;
        bus.resp_data_out[idx_out.id]  = bus.rowidx_in;
      end
      if (a_out.vld) begin
        bus.resp_valid_out[a_out.id] = 1'b1;
        bus.resp_data_out[a_out.id]  = bus.data_a_in;
      end
      if (b_out.vld) begin
        bus.resp_valid_out[b_out.id] = 1'b1;
        bus.resp_data_out[b_out.id]  = bus.data_b_in;
      end
    end
  end

  assign bus.idx_valid_out     = idx_valid_q;
  assign bus.idx_addr_out      = idx_addr_q;
  assign bus.data_validina_out = a_valid_q;
  assign bus.data_addra_out    = a_addr_q;
  assign bus.data_validinb_out = b_valid_q;
  assign bus.data_addrb_out    = b_addr_q;
  assign bus.inflight_out      = inflight_q;
endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Directed bench for graph_mem_arbiter with a 2-cycle BRAM model and hand-computed grants.
module tb_graph_mem_arbiter;
  localparam int NP = 4;
  localparam int PB = 2;
  localparam int RL = 2;

  typedef struct {
    logic              rst;
    logic [3:0]        v;
    logic [3:0]        k;
    logic [3:0][31:0]  a;
    int                iid;
    int                aid;
    int                bid;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  graph_mem_arbiter_if #(.NUM_PROCS(NP), .PROC_BITS(PB)) ifc();
  graph_mem_arbiter #(.NUM_PROCS(NP), .PROC_BITS(PB), .READ_LATENCY(RL)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (ifc.slave)
  );

  function automatic logic [31:0] f_idx(input logic [31:0] a);
    return 32'h1000_0000 + a * 32'd3;
  endfunction
  function automatic logic [31:0] f_dat(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  logic [31:0] ip0, ip1, ap0, ap1, bp0, bp1;
  always @(posedge clk) begin
    ip0 <= f_idx(ifc.idx_addr_out[31:0]);   ip1 <= ip0;
    ap0 <= f_dat(ifc.data_addra_out[31:0]); ap1 <= ap0;
    bp0 <= f_dat(ifc.data_addrb_out[31:0]); bp1 <= bp0;
  end
  assign ifc.rowidx_in = ip1;
  assign ifc.data_a_in = ap1;
  assign ifc.data_b_in = bp1;

  int          nchk = 0, nerr = 0, cyc = 0, exp_infl = 0;
  logic [3:0]  exp_rv [256];
  logic [31:0] exp_rd [256][4];
  logic        exp_iv, exp_av, exp_bv;
  logic [33:0] exp_ia, exp_aa, exp_ba;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic sched(input int id, input logic [31:0] w);
    exp_rv[cyc+3][id] = 1'b1;
    exp_rd[cyc+3][id] = w;
  endtask

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [3:0] k,
                              input int a0, input int a1, input int a2, input int a3,
                              input int iid, input int aid, input int bid);
    vec_t t;
    t.rst = r; t.v = v; t.k = k;
    t.a[0] = 32'(a0); t.a[1] = 32'(a1); t.a[2] = 32'(a2); t.a[3] = 32'(a3);
    t.iid = iid; t.aid = aid; t.bid = bid;
    return t;
  endfunction

  // One cycle: drive at negedge, check every output just after, then predict the next cycle.
  task automatic step(input vec_t t, output logic [3:0] got);
    logic [3:0] rdy;
    int         ng;
    @(negedge clk);
    rst              = t.rst;
    ifc.req_valid_in = t.v;
    ifc.req_kind_in  = t.k;
    ifc.req_addr_in  = t.a;
    #1;
    rdy = '0;
    ng  = 0;
    if (t.iid >= 0) begin rdy[t.iid] = 1'b1; ng++; end
    if (t.aid >= 0) begin rdy[t.aid] = 1'b1; ng++; end
    if (t.bid >= 0) begin rdy[t.bid] = 1'b1; ng++; end
    if (t.rst) exp_rv[cyc] = '0;
    got = ifc.req_ready_out;
    chk("ready", 64'(got), 64'(rdy));
    chk("resp_valid", 64'(ifc.resp_valid_out), 64'(exp_rv[cyc]));
    for (int i = 0; i < NP; i++)
      if (exp_rv[cyc][i]) chk("resp_data", 64'(ifc.resp_data_out[i]), 64'(exp_rd[cyc][i]));
    chk("inflight", 64'(ifc.inflight_out), 64'(exp_infl));
    chk("idx_valid", 64'(ifc.idx_valid_out), 64'(exp_iv));
    chk("idx_addr", 64'(ifc.idx_addr_out), 64'(exp_ia));
    chk("a_valid", 64'(ifc.data_validina_out), 64'(exp_av));
    chk("a_addr", 64'(ifc.data_addra_out), 64'(exp_aa));
    chk("b_valid", 64'(ifc.data_validinb_out), 64'(exp_bv));
    chk("b_addr", 64'(ifc.data_addrb_out), 64'(exp_ba));

    exp_infl = exp_infl + ng - $countones(exp_rv[cyc]);
    exp_iv = (t.iid >= 0);
    exp_av = (t.aid >= 0);
    exp_bv = (t.bid >= 0);
    if (t.iid >= 0) begin exp_ia = {2'(t.iid), t.a[t.iid]}; sched(t.iid, f_idx(t.a[t.iid])); end
    if (t.aid >= 0) begin exp_aa = {2'(t.aid), t.a[t.aid]}; sched(t.aid, f_dat(t.a[t.aid])); end
    if (t.bid >= 0) begin exp_ba = {2'(t.bid), t.a[t.bid]}; sched(t.bid, f_dat(t.a[t.bid])); end
    if (t.rst) begin
      for (int c = cyc + 1; c < 256; c++) exp_rv[c] = '0;
      exp_infl = 0;
      exp_iv = 1'b0; exp_av = 1'b0; exp_bv = 1'b0;
      exp_ia = '0;   exp_aa = '0;   exp_ba = '0;
    end
    cyc++;
  endtask

  initial begin
    vec_t       tbl[$];
    vec_t       idle;
    logic [3:0] g;
    int         gcnt[4];
    int         last[4];
    int         c0;

    ifc.req_valid_in = '0;
    ifc.req_kind_in  = '0;
    ifc.req_addr_in  = '0;
    for (int c = 0; c < 256; c++) begin
      exp_rv[c] = '0;
      for (int i = 0; i < 4; i++) exp_rd[c][i] = '0;
    end
    exp_iv = 1'b0; exp_av = 1'b0; exp_bv = 1'b0;
    exp_ia = '0;   exp_aa = '0;   exp_ba = '0;
    idle = mk(1'b0, 4'b0000, 4'b0000, 0, 0, 0, 0, -1, -1, -1);

    // Reset state, single idx read, 4-way data burst, mixed traffic, idx pointer wrap
    tbl.push_back(idle);
    tbl.push_back(mk(1'b0, 4'b0010, 4'b0000, 0, 5, 0, 0, 1, -1, -1));
    repeat (4) tbl.push_back(idle);
    tbl.push_back(mk(1'b0, 4'b1111, 4'b1111, 10, 11, 12, 13, -1, 0, 1));
    tbl.push_back(mk(1'b0, 4'b1100, 4'b1100, 10, 11, 12, 13, -1, 2, 3));
    repeat (4) tbl.push_back(idle);
    tbl.push_back(mk(1'b0, 4'b1111, 4'b1110, 20, 21, 22, 23, 0, 1, 2));
    tbl.push_back(mk(1'b0, 4'b1000, 4'b1000, 20, 21, 22, 23, -1, 3, -1));
    repeat (4) tbl.push_back(idle);
    tbl.push_back(mk(1'b0, 4'b1001, 4'b0000, 30, 0, 0, 33, 3, -1, -1));
    tbl.push_back(mk(1'b0, 4'b0001, 4'b0000, 30, 0, 0, 33, 0, -1, -1));
    repeat (4) tbl.push_back(idle);

    repeat (2) @(posedge clk);
    for (int n = 0; n < tbl.size(); n++) step(tbl[n], g);

    // Fairness: all four hold data requests for 20 cycles
    for (int i = 0; i < 4; i++) begin gcnt[i] = 0; last[i] = cyc - 1; end
    for (int c = 0; c < 20; c++) begin
      c0 = cyc;
      step(mk(1'b0, 4'b1111, 4'b1111, 100 + 4*c, 101 + 4*c, 102 + 4*c, 103 + 4*c,
              -1, (c % 2) * 2, (c % 2) * 2 + 1), g);
      for (int i = 0; i < 4; i++)
        if (g[i]) begin
          gcnt[i]++;
          chk("fair_gap", 64'((c0 - last[i]) <= 2), 64'(1));
          last[i] = c0;
        end
    end
    for (int i = 0; i < 4; i++) chk("fair_cnt", 64'(gcnt[i]), 64'(10));
    repeat (4) step(idle, g);

    // Reset mid-flight drops three reads; pointers restart at 0 afterwards
    step(mk(1'b0, 4'b0111, 4'b0110, 40, 41, 42, 0, 0, 1, 2), g);
    step(idle, g);
    step(mk(1'b1, 4'b0000, 4'b0000, 0, 0, 0, 0, -1, -1, -1), g);
    step(idle, g);
    step(mk(1'b0, 4'b1011, 4'b1001, 50, 52, 0, 53, 1, 0, 3), g);
    repeat (4) step(idle, g);

    // Back-to-back from one requester stays on port A
    for (int c = 0; c < 8; c++) step(mk(1'b0, 4'b0100, 4'b0100, 0, 0, c, 0, -1, 2, -1), g);
    repeat (4) step(idle, g);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
